// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler: shifts 1-bit input into a DATA_WIDTH accumulator
// and hands each completed word to a single-entry valid/ready output register.
module serial_word_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            clr,
  input  logic                            sin_valid,
  input  logic                            sin_bit,
  output logic                            sin_ready,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic [$clog2(DATA_WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  // Handshake rule for both sides: a beat moves only on a rising edge where
  // valid && ready; a producer holding valid keeps its data stable until then.
  logic [DATA_WIDTH-1:0] acc;
  logic                  acc_full;
  logic                  accept;
  logic                  xfer;

  assign acc_full  = (bit_cnt == CW'(DATA_WIDTH));
  assign sin_ready = !acc_full && !clr;
  assign accept    = sin_valid && sin_ready;
  // clr wins over a pending full accumulator, so the word is discarded not sent.
  assign xfer      = acc_full && !clr && (!dout_valid || dout_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (xfer) begin
      bit_cnt <= '0;
    end else if (accept) begin
      if (LSB_FIRST)
        acc <= {sin_bit, acc[DATA_WIDTH-1:1]};
      else
        acc <= {acc[DATA_WIDTH-2:0], sin_bit};
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (xfer) begin
      dout       <= acc;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
